// File: rtl/grf_hazard_scoreboard_pkg.sv
// Shared encodings and timing constants for the GRF hazard scoreboard.
// Forwarding-source encoding, pipeline depth and MDU latencies.
package grf_hazard_scoreboard_pkg;

  localparam int NREG     = 32;
  localparam int PIPE_WB  = 3;
  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;
  localparam int CW       = 4;

  typedef enum logic [1:0] {
    FWD_GRF = 2'd0,
    FWD_E   = 2'd1,
    FWD_M   = 2'd2,
    FWD_W   = 2'd3
  } fwd_t;

  // A producer with WbRem cycles left sits PIPE_WB-WbRem+1 stages past D.
  function automatic logic [1:0] fwd_encode(input logic vld, input logic [CW-1:0] wb_rem);
    logic [CW-1:0] stage;
    stage = CW'(PIPE_WB) - wb_rem + CW'(1);
    if (!vld || wb_rem == '0 || wb_rem > CW'(PIPE_WB)) begin
      return FWD_GRF;
    end
    return stage[1:0];
  endfunction

endpackage

// File: rtl/grf_hazard_scoreboard_entry.sv
// One scoreboard entry: tracks the newest in-flight write to a single GRF register.
// Issue beats flush, flush beats decrement/retire.
module grf_sb_entry
  import grf_hazard_scoreboard_pkg::*;
(
  input  logic          Clk,
  input  logic          Rst,
  input  logic          issue,
  input  logic [1:0]    issue_tnew,
  input  logic          flush,
  output logic          vld,
  output logic [CW-1:0] tnew_rem,
  output logic [CW-1:0] wb_rem
);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      vld      <= 1'b0;
      tnew_rem <= '0;
      wb_rem   <= '0;
    end else if (issue) begin
      vld      <= 1'b1;
      tnew_rem <= CW'(issue_tnew);
      wb_rem   <= CW'(PIPE_WB);
    end else if (flush && wb_rem >= CW'(2)) begin
      // Producer still in E or M is killed; a W-stage producer still writes.
      vld      <= 1'b0;
      tnew_rem <= '0;
      wb_rem   <= '0;
    end else if (vld) begin
      if (tnew_rem != '0) tnew_rem <= tnew_rem - CW'(1);
      if (wb_rem != '0)   wb_rem   <= wb_rem - CW'(1);
      if (wb_rem <= CW'(1)) vld <= 1'b0;
    end
  end

endmodule

// File: rtl/grf_hazard_scoreboard.sv
// D-stage hazard scoreboard: stall decision, per-operand forwarding select, MDU busy window.
// One entry per GRF register 1..31; register 0 is hard-wired as never busy.
module grf_hazard_scoreboard
  import grf_hazard_scoreboard_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       D_Valid,
  input  logic [4:0] D_Rs,
  input  logic [1:0] D_RsTuse,
  input  logic [4:0] D_Rt,
  input  logic [1:0] D_RtTuse,
  input  logic [4:0] D_Rd,
  input  logic [1:0] D_Tnew,
  input  logic       D_UseMD,
  input  logic       E_MDStart,
  input  logic       E_MDIsDiv,
  input  logic       Flush,
  output logic       Stall,
  output logic [1:0] FwdRs,
  output logic [1:0] FwdRt,
  output logic       MDBusy
);

  logic          vld      [NREG];
  logic [CW-1:0] tnew_rem [NREG];
  logic [CW-1:0] wb_rem   [NREG];
  logic [CW-1:0] md_cnt;
  logic          issue_ok;
  logic          rs_haz;
  logic          rt_haz;
  logic          md_haz;

  assign vld[0]      = 1'b0;
  assign tnew_rem[0] = '0;
  assign wb_rem[0]   = '0;

  // Handshake: D_Valid is the offer, !Stall is the accept; the instruction
  // leaves D on the edge where both hold and Flush is low.
  assign issue_ok = D_Valid && !Stall && !Flush && (D_Rd != 5'd0);

  for (genvar r = 1; r < NREG; r++) begin : g_ent
    grf_sb_entry u_ent (
      .Clk        (Clk),
      .Rst        (Rst),
      .issue      (issue_ok && (D_Rd == 5'(r))),
      .issue_tnew (D_Tnew),
      .flush      (Flush),
      .vld        (vld[r]),
      .tnew_rem   (tnew_rem[r]),
      .wb_rem     (wb_rem[r])
    );
  end

  always_comb begin
    rs_haz = (D_Rs != 5'd0) && vld[D_Rs] && (tnew_rem[D_Rs] > CW'(D_RsTuse));
    rt_haz = (D_Rt != 5'd0) && vld[D_Rt] && (tnew_rem[D_Rt] > CW'(D_RtTuse));
    md_haz = D_UseMD && ((md_cnt != '0) || E_MDStart);
    Stall  = D_Valid && (rs_haz || rt_haz || md_haz);
    FwdRs  = fwd_encode((D_Rs != 5'd0) && vld[D_Rs], wb_rem[D_Rs]);
    FwdRt  = fwd_encode((D_Rt != 5'd0) && vld[D_Rt], wb_rem[D_Rt]);
  end

  // Flush does not touch the MDU: an operation already started runs to completion.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      md_cnt <= '0;
    end else if (E_MDStart) begin
      md_cnt <= E_MDIsDiv ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CW'(1);
    end
  end

  assign MDBusy = (md_cnt != '0);

endmodule

// File: tb/tb_grf_hazard_scoreboard.sv
// Self-checking bench: instruction-age model of the pipeline plus directed hazard scenarios.
module tb_grf_hazard_scoreboard;

  logic       Clk;
  logic       Rst;
  logic       D_Valid;
  logic [4:0] D_Rs;
  logic [1:0] D_RsTuse;
  logic [4:0] D_Rt;
  logic [1:0] D_RtTuse;
  logic [4:0] D_Rd;
  logic [1:0] D_Tnew;
  logic       D_UseMD;
  logic       E_MDStart;
  logic       E_MDIsDiv;
  logic       Flush;
  logic       Stall;
  logic [1:0] FwdRs;
  logic [1:0] FwdRt;
  logic       MDBusy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  grf_hazard_scoreboard dut (
    .Clk(Clk), .Rst(Rst), .D_Valid(D_Valid), .D_Rs(D_Rs), .D_RsTuse(D_RsTuse),
    .D_Rt(D_Rt), .D_RtTuse(D_RtTuse), .D_Rd(D_Rd), .D_Tnew(D_Tnew),
    .D_UseMD(D_UseMD), .E_MDStart(E_MDStart), .E_MDIsDiv(E_MDIsDiv), .Flush(Flush),
    .Stall(Stall), .FwdRs(FwdRs), .FwdRt(FwdRt), .MDBusy(MDBusy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // ---------------- model: in-flight instructions by issue cycle ----------------
  typedef struct { int rd; int ic; int tnew; } inst_t;
  inst_t inflight[$];
  int md_start = 0;
  int md_len   = 0;

  function automatic int find_newest(input int r);
    for (int i = inflight.size() - 1; i >= 0; i--)
      if (inflight[i].rd == r) return i;
    return -1;
  endfunction

  function automatic logic src_haz(input int s, input int tuse);
    int idx;
    int rem;
    if (s == 0) return 1'b0;
    idx = find_newest(s);
    if (idx < 0) return 1'b0;
    rem = inflight[idx].tnew - (cyc - inflight[idx].ic - 1);
    if (rem < 0) rem = 0;
    return rem > tuse;
  endfunction

  function automatic logic [1:0] src_fwd(input int s);
    int idx;
    if (s == 0) return 2'd0;
    idx = find_newest(s);
    if (idx < 0) return 2'd0;
    return 2'(cyc - inflight[idx].ic);
  endfunction

  function automatic logic md_busy();
    return (md_len > 0) && (cyc > md_start) && (cyc <= md_start + md_len);
  endfunction

  function automatic logic exp_stall();
    return D_Valid && (src_haz(int'(D_Rs), int'(D_RsTuse)) ||
                       src_haz(int'(D_Rt), int'(D_RtTuse)) ||
                       (D_UseMD && (md_busy() || E_MDStart)));
  endfunction

  initial begin
    logic st;
    forever begin
      @(posedge Clk);
      if (Rst) begin
        inflight.delete();
        md_len = 0;
      end else begin
        st = exp_stall();
        if (Flush)
          for (int i = inflight.size() - 1; i >= 0; i--)
            if (cyc - inflight[i].ic == 1 || cyc - inflight[i].ic == 2) inflight.delete(i);
        if (D_Valid && !st && !Flush && D_Rd != 5'd0) begin
          for (int i = inflight.size() - 1; i >= 0; i--)
            if (inflight[i].rd == int'(D_Rd)) inflight.delete(i);
          inflight.push_back('{int'(D_Rd), cyc, int'(D_Tnew)});
        end
        if (E_MDStart) begin
          md_start = cyc;
          md_len   = E_MDIsDiv ? 10 : 5;
        end
      end
      cyc++;
      for (int i = inflight.size() - 1; i >= 0; i--)
        if (cyc - inflight[i].ic >= 4) inflight.delete(i);
    end
  end

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin
    logic es;
    forever begin
      @(negedge Clk);
      if (!Rst) begin
        es = exp_stall();
        chk("model_stall", 8'(Stall), 8'(es));
        chk("model_mdbusy", 8'(MDBusy), 8'(md_busy()));
        if (!es) begin
          chk("model_fwdrs", 8'(FwdRs), 8'(src_fwd(int'(D_Rs))));
          chk("model_fwdrt", 8'(FwdRt), 8'(src_fwd(int'(D_Rt))));
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [4:0] rs, input logic [1:0] rsu,
                       input logic [4:0] rt, input logic [1:0] rtu, input logic [4:0] rd,
                       input logic [1:0] tn, input logic umd, input logic mds,
                       input logic isdiv, input logic fl);
    @(posedge Clk);
    #1;
    Rst = 1'b0; D_Valid = v; D_Rs = rs; D_RsTuse = rsu; D_Rt = rt; D_RtTuse = rtu;
    D_Rd = rd; D_Tnew = tn; D_UseMD = umd; E_MDStart = mds; E_MDIsDiv = isdiv; Flush = fl;
    @(negedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    Rst = 1'b1; D_Valid = 0; D_Rs = 0; D_RsTuse = 0; D_Rt = 0; D_RtTuse = 0;
    D_Rd = 0; D_Tnew = 0; D_UseMD = 0; E_MDStart = 0; E_MDIsDiv = 0; Flush = 0;
    repeat (3) @(posedge Clk);

    idle(1);
    chk("reset_stall", 8'(Stall), 8'd0);
    chk("reset_fwdrs", 8'(FwdRs), 8'd0);
    chk("reset_fwdrt", 8'(FwdRt), 8'd0);
    chk("reset_mdbusy", 8'(MDBusy), 8'd0);

    // lw $8 (Tnew=2) then addu $9,$8 (Tuse=0)
    drive(1, 0, 0, 0, 0, 8, 2, 0, 0, 0, 0);
    chk("lw_issue_stall", 8'(Stall), 8'd0);
    drive(1, 8, 0, 0, 0, 9, 1, 0, 0, 0, 0);
    chk("lw_use_stall1", 8'(Stall), 8'd1);
    drive(1, 8, 0, 0, 0, 9, 1, 0, 0, 0, 0);
    chk("lw_use_stall2", 8'(Stall), 8'd1);
    drive(1, 8, 0, 0, 0, 9, 1, 0, 0, 0, 0);
    chk("lw_use_go", 8'(Stall), 8'd0);
    chk("lw_use_fwd_w", 8'(FwdRs), 8'd3);
    idle(4);

    // addu $8 (Tnew=1) then beq $8 (Tuse=0)
    drive(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0);
    drive(1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("beq_stall", 8'(Stall), 8'd1);
    drive(1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("beq_go", 8'(Stall), 8'd0);
    chk("beq_fwd_m", 8'(FwdRs), 8'd2);
    idle(4);

    // addu $8 then addu $10,$8,$8 (Tuse=1): forward from E on both operands
    drive(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0);
    drive(1, 8, 1, 8, 1, 10, 1, 0, 0, 0, 0);
    chk("alu_nostall", 8'(Stall), 8'd0);
    chk("alu_fwdrs_e", 8'(FwdRs), 8'd1);
    chk("alu_fwdrt_e", 8'(FwdRt), 8'd1);
    idle(4);

    // WAW: ori $5 then lui $5; reader of $5 follows the lui through E/M/W
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    drive(1, 5, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("waw_e", 8'(FwdRs), 8'd1);
    drive(1, 5, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("waw_m", 8'(FwdRs), 8'd2);
    drive(1, 5, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("waw_w", 8'(FwdRs), 8'd3);
    drive(1, 5, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("waw_retired", 8'(FwdRs), 8'd0);
    idle(3);

    // Flush with $6 in W, $4 in M, $3 in E; D writer of $7 is suppressed
    drive(1, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
    drive(1, 6, 0, 4, 0, 7, 0, 0, 0, 0, 1);
    chk("flush_fwd_w", 8'(FwdRs), 8'd3);
    chk("flush_fwd_m", 8'(FwdRt), 8'd2);
    drive(1, 3, 0, 4, 0, 0, 0, 0, 0, 0, 0);
    chk("flush_kill_e", 8'(FwdRs), 8'd0);
    chk("flush_kill_m", 8'(FwdRt), 8'd0);
    drive(1, 6, 0, 7, 0, 0, 0, 0, 0, 0, 0);
    chk("flush_w_retired", 8'(FwdRs), 8'd0);
    chk("flush_no_issue", 8'(FwdRt), 8'd0);
    idle(3);

    // div starts in E, mflo waits in D
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    chk("div_start_stall", 8'(Stall), 8'd0);
    chk("div_start_busy", 8'(MDBusy), 8'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0);
      if (Stall !== 1'b1) break;
      n++;
      chk("div_busy", 8'(MDBusy), 8'd1);
    end
    chk("div_stall_cycles", 8'(n), 8'd10);
    chk("div_done_busy", 8'(MDBusy), 8'd0);
    idle(4);

    // mult with a flush mid-count
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 0, 0, 2, 0, 1, 0, 0, (i == 2));
      if (Stall !== 1'b1) break;
      n++;
      chk("mult_busy", 8'(MDBusy), 8'd1);
    end
    chk("mult_stall_cycles", 8'(n), 8'd5);
    idle(4);

    // self-dependence: addu $12,$12 checks the pre-issue entry
    drive(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0);
    drive(1, 12, 0, 0, 0, 12, 1, 0, 0, 0, 0);
    chk("self_stall", 8'(Stall), 8'd1);
    drive(1, 12, 0, 0, 0, 12, 1, 0, 0, 0, 0);
    chk("self_go", 8'(Stall), 8'd0);
    chk("self_fwd_m", 8'(FwdRs), 8'd2);
    drive(1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("self_new_e", 8'(FwdRs), 8'd1);
    idle(4);

    // reset mid-operation with a producer and a div in flight
    drive(1, 0, 0, 0, 0, 13, 2, 0, 1, 1, 0);
    @(posedge Clk);
    #1;
    Rst = 1'b1; D_Valid = 1; D_Rd = 14; D_Tnew = 3; E_MDStart = 1; E_MDIsDiv = 1;
    drive(1, 13, 0, 14, 0, 0, 0, 1, 0, 0, 0);
    chk("midrst_stall", 8'(Stall), 8'd0);
    chk("midrst_fwdrs", 8'(FwdRs), 8'd0);
    chk("midrst_fwdrt", 8'(FwdRt), 8'd0);
    chk("midrst_mdbusy", 8'(MDBusy), 8'd0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
